// File: rtl/vga_source_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : vga_source_arbiter
// Purpose  : Frame-synchronous round-robin arbiter selecting one of four video
//            sources, with a minimum hold time and a registered video mux.
// Revision : 1.0 - initial release
// ============================================================================
module vga_source_arbiter #(
    parameter int COLOR_BITS  = 3,
    parameter int ACTIVE_COLS = 640,
    parameter int ACTIVE_ROWS = 480,
    parameter int MIN_FRAMES  = 2
) (
    input  logic                    i_Clk,
    input  logic                    i_Rst,
    input  logic [9:0]              i_Col_Count,
    input  logic [9:0]              i_Row_Count,
    input  logic [3:0]              i_Req,
    input  logic [4*COLOR_BITS-1:0] i_Red_Video,
    input  logic [4*COLOR_BITS-1:0] i_Grn_Video,
    input  logic [4*COLOR_BITS-1:0] i_Blu_Video,
    output logic [3:0]              o_Grant,
    output logic                    o_Frame_Tick,
    output logic                    o_Switch,
    output logic [COLOR_BITS-1:0]   o_Red_Video,
    output logic [COLOR_BITS-1:0]   o_Grn_Video,
    output logic [COLOR_BITS-1:0]   o_Blu_Video
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_OWNED = 1'b1
    } state_t;

    localparam logic [3:0] C_MIN_FRAMES = 4'(MIN_FRAMES);

    state_t                  state_q, state_d;
    logic [3:0]              grant_q, grant_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [1:0]              rr_q, rr_d;
    logic                    tick_q;
    logic                    switch_q;
    logic [COLOR_BITS-1:0]   red_q, grn_q, blu_q;

    logic                    w_boundary;
    logic                    w_active;
    logic [3:0]              w_cnt_inc;
    logic [3:0]              w_others;
    logic                    w_owner_req;
    logic                    w_take;
    logic [3:0]              w_pick;
    logic [COLOR_BITS-1:0]   w_red, w_grn, w_blu;

    // First requester at or after ptr, searching upward modulo 4; one-hot result.
    function automatic logic [3:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
        logic [3:0] pick;
        logic [1:0] idx;
        pick = '0;
        for (int i = 3; i >= 0; i--) begin
            idx = ptr + 2'(i);
            if (req[idx]) pick = 4'b0001 << idx;
        end
        return pick;
    endfunction

    function automatic logic [1:0] onehot_idx(input logic [3:0] oh);
        logic [1:0] idx;
        idx = '0;
        for (int i = 0; i < 4; i++) begin
            if (oh[i]) idx = 2'(i);
        end
        return idx;
    endfunction

    assign w_boundary  = (i_Row_Count == 10'(ACTIVE_ROWS)) && (i_Col_Count == 10'd0);
    assign w_active    = (i_Col_Count < 10'(ACTIVE_COLS)) && (i_Row_Count < 10'(ACTIVE_ROWS));
    assign w_cnt_inc   = (cnt_q >= C_MIN_FRAMES) ? cnt_q : cnt_q + 4'd1;
    assign w_others    = i_Req & ~grant_q;
    assign w_owner_req = |(i_Req & grant_q);

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        cnt_d   = cnt_q;
        rr_d    = rr_q;
        w_take  = 1'b0;
        w_pick  = '0;
        if (w_boundary) begin
            case (state_q)
                ST_IDLE: begin
                    w_take = 1'b1;
                    w_pick = rr_pick(i_Req, rr_q);
                end
                ST_OWNED: begin
                    cnt_d = w_cnt_inc;
                    // The owner's own bit is already clear in i_Req when it has released.
                    if (!w_owner_req) begin
                        w_take = 1'b1;
                        w_pick = rr_pick(i_Req, rr_q);
                    end else if ((w_cnt_inc >= C_MIN_FRAMES) && (|w_others)) begin
                        w_take = 1'b1;
                        w_pick = rr_pick(w_others, rr_q);
                    end
                end
                default: ;
            endcase
        end
        if (w_take) begin
            grant_d = w_pick;
            cnt_d   = 4'd0;
            if (|w_pick) rr_d = onehot_idx(w_pick) + 2'd1;
        end
        state_d = (|grant_d) ? ST_OWNED : ST_IDLE;
    end

    always_comb begin
        w_red = '0;
        w_grn = '0;
        w_blu = '0;
        for (int k = 0; k < 4; k++) begin
            if (grant_q[k]) begin
                w_red = i_Red_Video[k*COLOR_BITS +: COLOR_BITS];
                w_grn = i_Grn_Video[k*COLOR_BITS +: COLOR_BITS];
                w_blu = i_Blu_Video[k*COLOR_BITS +: COLOR_BITS];
            end
        end
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            cnt_q    <= '0;
            rr_q     <= '0;
            tick_q   <= 1'b0;
            switch_q <= 1'b0;
            red_q    <= '0;
            grn_q    <= '0;
            blu_q    <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            cnt_q    <= cnt_d;
            rr_q     <= rr_d;
            tick_q   <= w_boundary;
            switch_q <= (grant_d != grant_q);
            // Video follows the registered grant, so a new owner appears one cycle after the switch.
            if ((|grant_q) && w_active) begin
                red_q <= w_red;
                grn_q <= w_grn;
                blu_q <= w_blu;
            end else begin
                red_q <= '0;
                grn_q <= '0;
                blu_q <= '0;
            end
        end
    end

    assign o_Grant      = grant_q;
    assign o_Frame_Tick = tick_q;
    assign o_Switch     = switch_q;
    assign o_Red_Video  = red_q;
    assign o_Grn_Video  = grn_q;
    assign o_Blu_Video  = blu_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_source_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_source_arbiter
// Purpose  : Directed, table-driven bench for vga_source_arbiter on a small
//            8x4 active area with MIN_FRAMES = 2.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_source_arbiter;

    localparam int CB = 3;

    logic          clk;
    logic          rst;
    logic [9:0]    col, row;
    logic [3:0]    req;
    logic [4*CB-1:0] red_in, grn_in, blu_in;
    logic [3:0]    grant;
    logic          tick, sw;
    logic [CB-1:0] red, grn, blu;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [3:0] req;
        int         row;
        int         col;
        logic [3:0] grant;
        logic       sw;
        logic       tick;
        logic [2:0] r, g, b;
    } vec_t;

    vec_t vt[$];

    vga_source_arbiter #(
        .COLOR_BITS (CB),
        .ACTIVE_COLS(8),
        .ACTIVE_ROWS(4),
        .MIN_FRAMES (2)
    ) dut (
        .i_Clk       (clk),
        .i_Rst       (rst),
        .i_Col_Count (col),
        .i_Row_Count (row),
        .i_Req       (req),
        .i_Red_Video (red_in),
        .i_Grn_Video (grn_in),
        .i_Blu_Video (blu_in),
        .o_Grant     (grant),
        .o_Frame_Tick(tick),
        .o_Switch    (sw),
        .o_Red_Video (red),
        .o_Grn_Video (grn),
        .o_Blu_Video (blu)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [11:0] act, input logic [11:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cyc(input logic [3:0] r_in, input int rw, input int cl);
        @(negedge clk);
        req = r_in;
        row = 10'(rw);
        col = 10'(cl);
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic [3:0] rq, input int rw, input int cl, input logic [3:0] g,
                       input logic s, input logic t, input logic [2:0] r, input logic [2:0] gr,
                       input logic [2:0] b);
        vec_t v;
        v.req = rq; v.row = rw; v.col = cl; v.grant = g; v.sw = s; v.tick = t;
        v.r = r; v.g = gr; v.b = b;
        vt.push_back(v);
    endtask

    initial begin
        int   nsw;
        logic [3:0] rq;
        // Source k: red = k+1, green = k+4, blue = 7-k.
        red_in = {3'd4, 3'd3, 3'd2, 3'd1};
        grn_in = {3'd7, 3'd6, 3'd5, 3'd4};
        blu_in = {3'd4, 3'd5, 3'd6, 3'd7};
        rst = 1'b1;
        req = 4'b0000;
        row = 10'd0;
        col = 10'd0;

        //   req      row col grant    sw tick  r g b
        add(4'b0100, 0, 0, 4'b0000, 0, 0, 0, 0, 0);
        add(4'b0100, 4, 0, 4'b0100, 1, 1, 0, 0, 0);
        add(4'b0100, 0, 1, 4'b0100, 0, 0, 3, 6, 5);
        add(4'b0100, 0, 8, 4'b0100, 0, 0, 0, 0, 0);
        add(4'b0000, 1, 2, 4'b0100, 0, 0, 3, 6, 5);
        add(4'b0000, 4, 0, 4'b0000, 1, 1, 0, 0, 0);
        add(4'b0000, 0, 0, 4'b0000, 0, 0, 0, 0, 0);
        add(4'b0011, 4, 0, 4'b0001, 1, 1, 0, 0, 0);
        add(4'b0011, 4, 1, 4'b0001, 0, 0, 0, 0, 0);
        add(4'b0011, 4, 0, 4'b0001, 0, 1, 0, 0, 0);
        add(4'b0011, 2, 3, 4'b0001, 0, 0, 1, 4, 7);
        add(4'b0011, 4, 0, 4'b0010, 1, 1, 0, 0, 0);
        add(4'b1111, 0, 7, 4'b0010, 0, 0, 2, 5, 6);
        add(4'b1111, 4, 0, 4'b0010, 0, 1, 0, 0, 0);
        add(4'b1111, 4, 0, 4'b0100, 1, 1, 0, 0, 0);
        add(4'b1111, 4, 0, 4'b0100, 0, 1, 0, 0, 0);
        add(4'b1111, 4, 0, 4'b1000, 1, 1, 0, 0, 0);
        add(4'b1111, 4, 0, 4'b1000, 0, 1, 0, 0, 0);
        add(4'b1111, 4, 0, 4'b0001, 1, 1, 0, 0, 0);
        add(4'b0001, 0, 0, 4'b0001, 0, 0, 1, 4, 7);
        add(4'b0001, 4, 0, 4'b0001, 0, 1, 0, 0, 0);
        add(4'b0001, 4, 0, 4'b0001, 0, 1, 0, 0, 0);
        add(4'b0001, 4, 0, 4'b0001, 0, 1, 0, 0, 0);
        add(4'b1001, 0, 0, 4'b0001, 0, 0, 1, 4, 7);
        add(4'b1001, 4, 0, 4'b1000, 1, 1, 0, 0, 0);
        add(4'b0111, 3, 7, 4'b1000, 0, 0, 4, 7, 4);
        add(4'b0111, 4, 0, 4'b0001, 1, 1, 0, 0, 0);

        // Reset state, with a boundary presented on the counters while held.
        repeat (2) @(posedge clk);
        row = 10'd4;
        req = 4'b1111;
        @(posedge clk);
        #1;
        chk("reset grant", 12'(grant), 12'h0);
        chk("reset tick", 12'(tick), 12'h0);
        chk("reset switch", 12'(sw), 12'h0);
        chk("reset video", {red, grn, blu, 3'd0}, 12'h0);
        @(negedge clk);
        row = 10'd0;
        req = 4'b0000;
        rst = 1'b0;

        foreach (vt[i]) begin
            cyc(vt[i].req, vt[i].row, vt[i].col);
            chk($sformatf("vec%0d grant", i), 12'(grant), 12'(vt[i].grant));
            chk($sformatf("vec%0d switch", i), 12'(sw), 12'(vt[i].sw));
            chk($sformatf("vec%0d tick", i), 12'(tick), 12'(vt[i].tick));
            chk($sformatf("vec%0d video", i), {red, grn, blu, 3'd0},
                {vt[i].r, vt[i].g, vt[i].b, 3'd0});
        end

        // Requests toggle every 7 cycles over a full 10x6 scan; the owner (source 0)
        // is only released at the single boundary (scan cycle 40), where source 1 wins.
        nsw = 0;
        for (int n = 0; n < 60; n++) begin
            rq = (((n / 7) % 2) == 0) ? 4'b0001 : 4'b0110;
            cyc(rq, n / 10, n % 10);
            if (sw) nsw++;
            chk($sformatf("scan%0d grant", n), 12'(grant), (n >= 40) ? 12'h2 : 12'h1);
            chk($sformatf("scan%0d switch", n), 12'(sw), (n == 40) ? 12'h1 : 12'h0);
        end
        chk("scan switch count", 12'(nsw), 12'd1);

        // Asynchronous reset mid-frame while source 1 owns.
        cyc(4'b0010, 2, 3);
        chk("pre-rst video", {red, grn, blu, 3'd0}, {3'd2, 3'd5, 3'd6, 3'd0});
        #2;
        rst = 1'b1;
        #1;
        chk("async rst grant", 12'(grant), 12'h0);
        chk("async rst video", {red, grn, blu, 3'd0}, 12'h0);
        chk("async rst tick/sw", {10'd0, tick, sw}, 12'h0);
        cyc(4'b0010, 4, 0);
        chk("held rst grant", 12'(grant), 12'h0);
        @(negedge clk);
        rst = 1'b0;
        req = 4'b0010;
        row = 10'd2;
        col = 10'd4;
        @(posedge clk);
        #1;
        chk("post-rst no early grant", 12'(grant), 12'h0);
        cyc(4'b0010, 4, 0);
        chk("post-rst grant", 12'(grant), 12'h2);
        chk("post-rst switch", 12'(sw), 12'h1);
        cyc(4'b0010, 0, 0);
        chk("post-rst switch clear", 12'(sw), 12'h0);
        chk("post-rst video", {red, grn, blu, 3'd0}, {3'd2, 3'd5, 3'd6, 3'd0});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
